// File: rtl/qk_dot_if.sv
// Q / K-V / score handshake bundle between the QK score engine and its neighbours.
// The engine takes the slave side; the feeder/consumer pair takes the master side.
interface qk_dot_if #(
    parameter int DIM     = 64,
    parameter int ELEM_W  = 8,
    parameter int MAX_SEQ = 128,
    parameter int OUT_W   = 16
);
    localparam int VEC_W = DIM * ELEM_W;
    localparam int LEN_W = $clog2(MAX_SEQ + 1);

    logic                    q_vld;
    logic                    q_rdy;
    logic [VEC_W-1:0]        q_data;
    logic [LEN_W-1:0]        kv_len;
    logic                    kv_vld;
    logic                    kv_rdy;
    logic [VEC_W-1:0]        k_data;
    logic [VEC_W-1:0]        v_data;
    logic                    s_vld;
    logic                    s_rdy;
    logic signed [OUT_W-1:0] s_data;
    logic [VEC_W-1:0]        v_out;
    logic                    s_last;

    modport master (
        output q_vld, q_data, kv_len, kv_vld, k_data, v_data, s_rdy,
        input  q_rdy, kv_rdy, s_vld, s_data, v_out, s_last
    );

    modport slave (
        input  q_vld, q_data, kv_len, kv_vld, k_data, v_data, s_rdy,
        output q_rdy, kv_rdy, s_vld, s_data, v_out, s_last
    );
endinterface

// File: rtl/qk_dot_engine.sv
// Folded QK score engine: one resident Q vector, each K row reduced over DIM/LANES
// MAC beats, then shifted, saturated and emitted alongside its untouched V row.
module qk_dot_engine #(
    parameter int DIM         = 64,
    parameter int ELEM_W      = 8,
    parameter int LANES       = 16,
    parameter int MAX_SEQ     = 128,
    parameter int SCALE_SHIFT = 3,
    parameter int OUT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    qk_dot_if.slave    bus
);
    localparam int VEC_W  = DIM * ELEM_W;
    localparam int LANE_W = LANES * ELEM_W;
    localparam int BEATS  = DIM / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LEN_W  = $clog2(MAX_SEQ + 1);
    localparam int ACC_W  = 2 * ELEM_W + $clog2(DIM);

    localparam logic signed [ACC_W-1:0] C_ACC_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_ACC_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_KV, MAC, OUT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [VEC_W-1:0]        r_q;
    logic [VEC_W-1:0]        r_k;
    logic [VEC_W-1:0]        r_v;
    logic signed [ACC_W-1:0] r_acc;
    logic [BEAT_W-1:0]       r_beat;
    logic [LEN_W-1:0]        r_rows;
    logic [LEN_W-1:0]        r_row;
    logic signed [OUT_W-1:0] r_s_data;

    logic [LANE_W-1:0]         w_q_beat;
    logic [LANE_W-1:0]         w_k_beat;
    logic signed [2*ELEM_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0]   w_beat_sum;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic signed [ACC_W-1:0]   w_scaled;
    logic signed [OUT_W-1:0]   w_sat;
    logic                      w_last_beat;
    logic                      w_last_row;

    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_row  = (r_row == r_rows - LEN_W'(1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        bus.q_rdy   = 1'b0;
        bus.kv_rdy  = 1'b0;
        bus.s_vld   = 1'b0;
        bus.s_last  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.q_rdy = 1'b1;
                if (bus.q_vld && (bus.kv_len != '0)) w_state_nxt = WAIT_KV;
            end
            WAIT_KV: begin
                bus.kv_rdy = 1'b1;
                if (bus.kv_vld) w_state_nxt = MAC;
            end
            MAC: begin
                if (w_last_beat) w_state_nxt = OUT;
            end
            OUT: begin
                bus.s_vld  = 1'b1;
                bus.s_last = w_last_row;
                if (bus.s_rdy) w_state_nxt = w_last_row ? IDLE : WAIT_KV;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One beat's worth of lane products, sign-extended into the accumulator width.
    assign w_q_beat = r_q[int'(r_beat) * LANE_W +: LANE_W];
    assign w_k_beat = r_k[int'(r_beat) * LANE_W +: LANE_W];

    always_comb begin
        w_beat_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            w_prod[j]  = $signed(w_q_beat[j*ELEM_W +: ELEM_W]) * $signed(w_k_beat[j*ELEM_W +: ELEM_W]);
            w_beat_sum = w_beat_sum + ACC_W'(w_prod[j]);
        end
    end

    assign w_acc_nxt = r_acc + w_beat_sum;
    assign w_scaled  = w_acc_nxt >>> SCALE_SHIFT;

    always_comb begin
        if (w_scaled > C_ACC_MAX)      w_sat = C_OUT_MAX;
        else if (w_scaled < C_ACC_MIN) w_sat = C_OUT_MIN;
        else                           w_sat = w_scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_k      <= '0;
            r_v      <= '0;
            r_acc    <= '0;
            r_beat   <= '0;
            r_rows   <= '0;
            r_row    <= '0;
            r_s_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.q_vld) begin
                    r_q    <= bus.q_data;
                    r_rows <= (bus.kv_len > LEN_W'(MAX_SEQ)) ? LEN_W'(MAX_SEQ) : bus.kv_len;
                    r_row  <= '0;
                end
                WAIT_KV: if (bus.kv_vld) begin
                    r_k    <= bus.k_data;
                    r_v    <= bus.v_data;
                    r_acc  <= '0;
                    r_beat <= '0;
                end
                MAC: begin
                    r_acc  <= w_acc_nxt;
                    r_beat <= r_beat + BEAT_W'(1);
                    if (w_last_beat) r_s_data <= w_sat;
                end
                OUT: if (bus.s_rdy) r_row <= r_row + LEN_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.s_data = r_s_data;
    assign bus.v_out  = r_v;
endmodule

// File: tb/tb_qk_dot_engine.sv
// Randomised self-checking bench for qk_dot_engine against a plain-arithmetic
// dot-product / floor-shift / saturate reference model.
module tb_qk_dot_engine;
    localparam int DIM         = 64;
    localparam int ELEM_W      = 8;
    localparam int LANES       = 16;
    localparam int MAX_SEQ     = 128;
    localparam int SCALE_SHIFT = 3;
    localparam int OUT_W       = 16;
    localparam int BEATS       = DIM / LANES;
    localparam int VEC_W       = DIM * ELEM_W;
    localparam int LEN_W       = $clog2(MAX_SEQ + 1);

    typedef int vec_t [DIM];

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    qk_dot_if #(.DIM(DIM), .ELEM_W(ELEM_W), .MAX_SEQ(MAX_SEQ), .OUT_W(OUT_W)) bus ();

    qk_dot_engine #(
        .DIM(DIM), .ELEM_W(ELEM_W), .LANES(LANES), .MAX_SEQ(MAX_SEQ),
        .SCALE_SHIFT(SCALE_SHIFT), .OUT_W(OUT_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t fill(int val);
        vec_t a;
        foreach (a[i]) a[i] = val;
        return a;
    endfunction

    function automatic vec_t rand_vec();
        vec_t a;
        foreach (a[i]) a[i] = int'($urandom_range(255)) - 128;
        return a;
    endfunction

    function automatic logic [VEC_W-1:0] pack(vec_t a);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) r[i*ELEM_W +: ELEM_W] = ELEM_W'(a[i]);
        return r;
    endfunction

    // Reference: exact dot product, divide by 2^SCALE_SHIFT rounding toward -inf, clamp.
    function automatic int exp_score(vec_t q, vec_t k);
        longint raw, div, sc, hi, lo;
        raw = 0;
        for (int i = 0; i < DIM; i++) raw += longint'(q[i]) * longint'(k[i]);
        div = longint'(1) << SCALE_SHIFT;
        sc  = (raw >= 0) ? raw / div : -((-raw + div - 1) / div);
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        lo  = -(longint'(1) << (OUT_W - 1));
        if (sc > hi) sc = hi;
        if (sc < lo) sc = lo;
        return int'(sc);
    endfunction

    task automatic send_q(input vec_t q, input int len, input bit with_kv);
        check("q_rdy_idle", bus.q_rdy, 1);
        bus.q_vld  = 1'b1;
        bus.q_data = pack(q);
        bus.kv_len = LEN_W'(len);
        if (with_kv) begin
            bus.kv_vld = 1'b1;
            bus.k_data = pack(rand_vec());
            bus.v_data = pack(rand_vec());
        end
        @(negedge clk);
        bus.q_vld  = 1'b0;
        bus.kv_vld = 1'b0;
    endtask

    task automatic send_kv(input vec_t k, input logic [VEC_W-1:0] v, output int hs);
        int n;
        bus.kv_vld = 1'b1;
        bus.k_data = pack(k);
        bus.v_data = v;
        n = 0;
        while (bus.kv_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("kv_rdy_timeout", 0, 1);
        hs = cyc;
        @(negedge clk);
        bus.kv_vld = 1'b0;
    endtask

    task automatic recv(input int exp_s, input logic [VEC_W-1:0] exp_v, input bit exp_last,
                        input int hs, input int stall);
        int n;
        n = 0;
        while (bus.s_vld !== 1'b1 && n < 20) begin
            check("kv_rdy_busy", bus.kv_rdy, 0);
            bus.s_rdy = 1'($urandom_range(1));
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            bus.s_rdy = 1'b0;
            check("s_vld_timeout", 0, 1);
            return;
        end
        bus.s_rdy = 1'b0;
        check("latency", cyc - hs, BEATS + 1);
        check("s_data", $signed(bus.s_data), exp_s);
        check("v_out", bus.v_out, exp_v);
        check("s_last", bus.s_last, exp_last);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_s_vld", bus.s_vld, 1);
            check("stall_s_data", $signed(bus.s_data), exp_s);
            check("stall_v_out", bus.v_out, exp_v);
            check("stall_s_last", bus.s_last, exp_last);
            check("stall_kv_rdy", bus.kv_rdy, 0);
        end
        bus.s_rdy = 1'b1;
        @(negedge clk);
        bus.s_rdy = 1'b0;
    endtask

    task automatic run_q(input vec_t q, input int len, input bit use_k, input vec_t kf,
                         input int stall_row, input int stall_n, input bit with_kv);
        int rows, hs;
        vec_t k;
        logic [VEC_W-1:0] v;
        rows = (len > MAX_SEQ) ? MAX_SEQ : len;
        send_q(q, len, with_kv);
        for (int r = 0; r < rows; r++) begin
            k = use_k ? kf : rand_vec();
            v = pack(rand_vec());
            send_kv(k, v, hs);
            recv(exp_score(q, k), v, r == rows - 1, hs, (r == stall_row) ? stall_n : 0);
        end
        check("q_rdy_after", bus.q_rdy, 1);
        check("s_vld_after", bus.s_vld, 0);
    endtask

    initial begin
        vec_t q, k;
        logic [VEC_W-1:0] v;
        int hs;

        rst        = 1'b1;
        bus.q_vld  = 1'b0;
        bus.q_data = '0;
        bus.kv_len = '0;
        bus.kv_vld = 1'b0;
        bus.k_data = '0;
        bus.v_data = '0;
        bus.s_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_q_rdy", bus.q_rdy, 1);
        check("rst_kv_rdy", bus.kv_rdy, 0);
        check("rst_s_vld", bus.s_vld, 0);
        check("rst_s_last", bus.s_last, 0);
        check("rst_s_data", $signed(bus.s_data), 0);
        check("rst_v_out", bus.v_out, 0);
        rst = 1'b0;
        @(negedge clk);

        run_q(fill(1), 1, 1'b1, fill(2), -1, 0, 1'b0);
        run_q(fill(127), 1, 1'b1, fill(127), -1, 0, 1'b0);
        run_q(fill(-128), 1, 1'b1, fill(127), -1, 0, 1'b0);

        q = fill(0); q[0] = -1;
        k = fill(0); k[0] = 1;
        run_q(q, 1, 1'b1, k, -1, 0, 1'b0);
        q[0] = 7;
        run_q(q, 1, 1'b1, k, -1, 0, 1'b0);

        run_q(rand_vec(), 3, 1'b0, fill(0), 1, 4, 1'b1);

        send_q(rand_vec(), 0, 1'b0);
        repeat (10) begin
            check("len0_s_vld", bus.s_vld, 0);
            check("len0_q_rdy", bus.q_rdy, 1);
            check("len0_kv_rdy", bus.kv_rdy, 0);
            @(negedge clk);
        end
        run_q(rand_vec(), 2, 1'b0, fill(0), -1, 0, 1'b0);

        run_q(rand_vec(), 200, 1'b0, fill(0), 5, 2, 1'b0);

        q = rand_vec();
        send_q(q, 3, 1'b0);
        k = rand_vec();
        v = pack(rand_vec());
        send_kv(k, v, hs);
        recv(exp_score(q, k), v, 1'b0, hs, 0);
        send_kv(rand_vec(), pack(rand_vec()), hs);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_vld", bus.s_vld, 0);
        check("mid_rst_q_rdy", bus.q_rdy, 1);
        check("mid_rst_kv_rdy", bus.kv_rdy, 0);
        check("mid_rst_s_data", $signed(bus.s_data), 0);
        check("mid_rst_v_out", bus.v_out, 0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_quiet", bus.s_vld, 0);
        end
        run_q(rand_vec(), 2, 1'b0, fill(0), -1, 0, 1'b0);

        repeat (8) begin
            run_q(rand_vec(), int'($urandom_range(1, 5)), 1'b0, fill(0),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
